// File: rtl/bram_frame_pingpong_pkg.sv
// Shared definitions for the two-bank ping-pong frame buffer: bank ownership
// encoding, default widths and a saturating drop-counter helper.
package frame_buf_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 15;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_READY   = 2'd2,
    ST_READING = 2'd3
  } bank_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/bram_frame_pingpong_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// No reset so the array maps onto block RAM.
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int AW     = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_frame_pingpong.sv
// Two-bank frame buffer: writer fills one bank while the LCD re-reads the
// newest completed frame from the other; stale frames are dropped and counted.
module bram_frame_pingpong
  import frame_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_sof,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_eof,
  output logic              wr_ready,
  output logic              wr_overflow,
  input  logic              rd_req,
  output logic              rd_frame_valid,
  output logic [ADDR_W:0]   rd_frame_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic [7:0]        dropped_frames
);

  bank_state_e [1:0]       st_q, st_d;
  logic [1:0][ADDR_W:0]    len_q, len_d;
  logic [ADDR_W:0]         ptr_q, ptr_d, rlen_q, rlen_d, eof_len;
  logic                    newest_q, newest_d, rbank_q, rbank_d;
  logic                    ovf_q, ovf_d, wr_ready_q, rfv_q, rdv_q, rd_zero_q;
  logic [7:0]              drop_q;
  logic [1:0]              drops;
  logic                    fill_hit, fb, accept, eof_done, rsel, tgt, sof_ok;
  logic                    fill_after, wb, any_ready, wr_ready_d, rfv_d;
  logic                    we;
  logic [ADDR_W:0]         waddr;
  logic [DATA_W-1:0]       ram_rdata;

  // Rules are applied in the fixed order eof, rd_req, sof, then the byte write.
  always_comb begin
    st_d     = st_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    newest_d = newest_q;
    ovf_d    = ovf_q;
    rlen_d   = rlen_q;
    rbank_d  = rbank_q;
    drops    = 2'd0;
    we       = 1'b0;
    waddr    = '0;
    fill_hit = 1'b0;
    fb       = 1'b0;
    eof_done = 1'b0;
    eof_len  = '0;
    rsel     = 1'b0;
    tgt      = 1'b0;
    sof_ok   = 1'b0;
    fill_after = 1'b0;
    wb       = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (st_q[b] == ST_FILLING) begin
        fill_hit = 1'b1;
        fb       = 1'(b);
      end
    end
    accept = fill_hit && wr_valid && !ptr_q[ADDR_W];

    if (wr_eof && fill_hit) begin
      eof_done = 1'b1;
      eof_len  = ptr_q + {{ADDR_W{1'b0}}, accept};
      if (eof_len == '0) begin
        st_d[fb] = ST_EMPTY;
      end else begin
        st_d[fb]  = ST_READY;
        len_d[fb] = eof_len;
        newest_d  = fb;
        if (st_d[~fb] == ST_READY) begin
          st_d[~fb] = ST_EMPTY;
          drops     = drops + 2'd1;
        end
      end
    end

    any_ready = (st_d[0] == ST_READY) || (st_d[1] == ST_READY);
    if (rd_req && any_ready) begin
      rsel = (st_d[newest_d] == ST_READY) ? newest_d : ~newest_d;
      for (int b = 0; b < 2; b++) begin
        if (st_d[b] == ST_READING) st_d[b] = ST_EMPTY;
      end
      st_d[rsel] = ST_READING;
      rlen_d     = len_d[rsel];
      rbank_d    = rsel;
    end

    if (wr_sof) begin
      sof_ok = 1'b1;
      if (st_d[0] == ST_FILLING || st_d[1] == ST_FILLING) begin
        tgt   = (st_d[1] == ST_FILLING);
        drops = drops + 2'd1;
      end else if (st_d[0] == ST_EMPTY) begin
        tgt = 1'b0;
      end else if (st_d[1] == ST_EMPTY) begin
        tgt = 1'b1;
      end else if (st_d[0] == ST_READY) begin
        tgt   = 1'b0;
        drops = drops + 2'd1;
      end else if (st_d[1] == ST_READY) begin
        tgt   = 1'b1;
        drops = drops + 2'd1;
      end else begin
        sof_ok = 1'b0;
      end
      if (sof_ok) begin
        st_d[tgt] = ST_FILLING;
        ptr_d     = '0;
        ovf_d     = 1'b0;
      end
    end

    // A byte arriving with eof belongs to the frame being closed.
    if (eof_done) begin
      if (accept) begin
        we    = 1'b1;
        waddr = {fb, ptr_q[ADDR_W-1:0]};
      end else if (fill_hit && wr_valid && !wr_sof) begin
        ovf_d = 1'b1;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (st_d[b] == ST_FILLING) begin
          fill_after = 1'b1;
          wb         = 1'(b);
        end
      end
      if (wr_valid && fill_after) begin
        if (!ptr_d[ADDR_W]) begin
          we    = 1'b1;
          waddr = {wb, ptr_d[ADDR_W-1:0]};
          ptr_d = ptr_d + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    wr_ready_d = ((st_d[0] == ST_FILLING) || (st_d[1] == ST_FILLING)) && !ptr_d[ADDR_W];
    rfv_d      = (st_d[0] == ST_READING) || (st_d[1] == ST_READING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= {ST_EMPTY, ST_EMPTY};
      len_q      <= '0;
      ptr_q      <= '0;
      newest_q   <= 1'b0;
      ovf_q      <= 1'b0;
      rlen_q     <= '0;
      rbank_q    <= 1'b0;
      drop_q     <= 8'd0;
      wr_ready_q <= 1'b0;
      rfv_q      <= 1'b0;
      rdv_q      <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      st_q       <= st_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
      newest_q   <= newest_d;
      ovf_q      <= ovf_d;
      rlen_q     <= rlen_d;
      rbank_q    <= rbank_d;
      drop_q     <= sat_add8(drop_q, drops);
      wr_ready_q <= wr_ready_d;
      rfv_q      <= rfv_d;
      rdv_q      <= rd_en && rfv_q;
      // Gate is captured with the read so a swap mid-read cannot affect it.
      if (rd_en) rd_zero_q <= !rfv_q || ({1'b0, rd_addr} >= rlen_q);
    end
  end

  sdp_ram #(.DATA_W(DATA_W), .AW(ADDR_W + 1)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr ({rbank_q, rd_addr}),
    .rdata (ram_rdata)
  );

  assign wr_ready       = wr_ready_q;
  assign wr_overflow    = ovf_q;
  assign rd_frame_valid = rfv_q;
  assign rd_frame_len   = rlen_q;
  assign rd_data        = rd_zero_q ? '0 : ram_rdata;
  assign rd_data_valid  = rdv_q;
  assign dropped_frames = drop_q;

endmodule
